// File: rtl/ring_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ring_rr_arbiter
//   Four-requester round-robin arbiter with a one-hot rotating priority
//   pointer. A grant is held for as long as its owner keeps requesting.
//   On release the pointer moves one position past the old owner, and a
//   single idle turnaround cycle separates consecutive grants.
//
//   Optional feature (macro RING_RR_ARBITER_TIMEOUT_EN):
//     The owner is force-released after TIMEOUT_CYCLES consecutive grant
//     cycles. The timeout output then pulses for one cycle. The released
//     requester stays ineligible until it drops req for at least one
//     sampled cycle. Without the macro, grants are unbounded and timeout
//     is tied low.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   req[3:0]  in   request levels, bit i = requester i
//   gnt[3:0]  out  registered grant, one-hot or zero
//   grant_id  out  binary index of gnt (0 when gnt is zero)
//   busy      out  high while a grant is held
//   ptr[3:0]  out  one-hot priority pointer for the next arbitration
//   timeout   out  one-cycle pulse on forced release
// ---------------------------------------------------------------------------
module ring_rr_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic [3:0] ptr,
    output logic       timeout
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("ring_rr_arbiter: TIMEOUT_CYCLES must be in 2..255");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state, state_next;
    logic [3:0] gnt_next;
    logic [3:0] ptr_next;
    logic [3:0] elig;
    logic [3:0] pick;
    logic [1:0] ptr_idx;
    logic       owner_req;

`ifdef RING_RR_ARBITER_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] cnt, cnt_next;
    logic [3:0] mask, mask_next;
    logic       timeout_next;

    // A force-released requester stays out of arbitration until it drops req.
    assign elig = req & ~mask;
`else
    assign elig    = req;
    assign timeout = 1'b0;
`endif

    assign owner_req = |(req & gnt);
    assign busy      = (state == GRANT);

    always_comb begin
        ptr_idx = 2'd0;
        case (ptr)
            4'b0010: ptr_idx = 2'd1;
            4'b0100: ptr_idx = 2'd2;
            4'b1000: ptr_idx = 2'd3;
            default: ptr_idx = 2'd0;
        endcase
    end

    always_comb begin
        grant_id = 2'd0;
        case (gnt)
            4'b0010: grant_id = 2'd1;
            4'b0100: grant_id = 2'd2;
            4'b1000: grant_id = 2'd3;
            default: grant_id = 2'd0;
        endcase
    end

    // First eligible requester scanning upward from the pointer, with wrap.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        pick  = 4'b0000;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_idx + 2'(k);
            if (!found && elig[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        gnt_next   = gnt;
        ptr_next   = ptr;
`ifdef RING_RR_ARBITER_TIMEOUT_EN
        cnt_next     = cnt;
        timeout_next = 1'b0;
        mask_next    = mask & req;
`endif
        case (state)
            IDLE: begin
                if (|elig) begin
                    gnt_next   = pick;
                    state_next = GRANT;
`ifdef RING_RR_ARBITER_TIMEOUT_EN
                    cnt_next   = 8'd1;
`endif
                end else begin
                    gnt_next = 4'b0000;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    gnt_next   = 4'b0000;
                    state_next = IDLE;
                    ptr_next   = {gnt[2:0], gnt[3]};
`ifdef RING_RR_ARBITER_TIMEOUT_EN
                end else if (cnt == TIMEOUT_LIMIT) begin
                    gnt_next     = 4'b0000;
                    state_next   = IDLE;
                    ptr_next     = {gnt[2:0], gnt[3]};
                    timeout_next = 1'b1;
                    mask_next    = (mask & req) | gnt;
                end else begin
                    cnt_next = cnt + 8'd1;
`endif
                end
            end
            default: begin
                gnt_next   = 4'b0000;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            ptr   <= 4'b0001;
`ifdef RING_RR_ARBITER_TIMEOUT_EN
            cnt     <= 8'd0;
            mask    <= 4'b0000;
            timeout <= 1'b0;
`endif
        end else begin
            state <= state_next;
            gnt   <= gnt_next;
            ptr   <= ptr_next;
`ifdef RING_RR_ARBITER_TIMEOUT_EN
            cnt     <= cnt_next;
            mask    <= mask_next;
            timeout <= timeout_next;
`endif
        end
    end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ring_rr_arbiter
//   Directed bench for ring_rr_arbiter: a table of {req, expected gnt,
//   expected ptr} records applied one clock at a time, plus hand-written
//   sequences for asynchronous reset and grant timeout behaviour.
// ---------------------------------------------------------------------------
module tb_ring_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] grant_id;
    logic       busy;
    logic [3:0] ptr;
    logic       timeout;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [3:0] ptr;
    } vec_t;

    vec_t tbl[$];

    ring_rr_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .grant_id (grant_id),
        .busy     (busy),
        .ptr      (ptr),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    function automatic logic [3:0] enc(input logic [3:0] g);
        case (g)
            4'b0010: return 4'd1;
            4'b0100: return 4'd2;
            4'b1000: return 4'd3;
            default: return 4'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%b required=%b", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic [3:0] eg, input logic [3:0] ep,
                             input logic et);
        check({tag, " gnt"}, gnt, eg);
        check({tag, " grant_id"}, {2'b00, grant_id}, enc(eg));
        check({tag, " busy"}, {3'b000, busy}, {3'b000, |eg});
        check({tag, " ptr"}, ptr, ep);
        check({tag, " timeout"}, {3'b000, timeout}, {3'b000, et});
    endtask

    task automatic step(input logic [3:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Full rotation 0,1,2,3,0 with a turnaround between grants.
        tbl.push_back('{4'b1111, 4'b0001, 4'b0001});
        tbl.push_back('{4'b1111, 4'b0001, 4'b0001});
        tbl.push_back('{4'b1110, 4'b0000, 4'b0010});
        tbl.push_back('{4'b1111, 4'b0010, 4'b0010});
        tbl.push_back('{4'b1111, 4'b0010, 4'b0010});
        tbl.push_back('{4'b1101, 4'b0000, 4'b0100});
        tbl.push_back('{4'b1111, 4'b0100, 4'b0100});
        tbl.push_back('{4'b1111, 4'b0100, 4'b0100});
        tbl.push_back('{4'b1011, 4'b0000, 4'b1000});
        tbl.push_back('{4'b1111, 4'b1000, 4'b1000});
        tbl.push_back('{4'b1111, 4'b1000, 4'b1000});
        tbl.push_back('{4'b0111, 4'b0000, 4'b0001});
        tbl.push_back('{4'b1111, 4'b0001, 4'b0001});
        tbl.push_back('{4'b1111, 4'b0001, 4'b0001});
        tbl.push_back('{4'b1110, 4'b0000, 4'b0010});
        // Idle with no requests: pointer holds.
        tbl.push_back('{4'b0000, 4'b0000, 4'b0010});
        tbl.push_back('{4'b0000, 4'b0000, 4'b0010});
        // Move pointer to 0100, then wrap-around scan picks requester 0.
        tbl.push_back('{4'b0010, 4'b0010, 4'b0010});
        tbl.push_back('{4'b0000, 4'b0000, 4'b0100});
        tbl.push_back('{4'b0011, 4'b0001, 4'b0100});
        tbl.push_back('{4'b0011, 4'b0001, 4'b0100});
        // Release with another requester pending: turnaround cycle first.
        tbl.push_back('{4'b0010, 4'b0000, 4'b0010});
        tbl.push_back('{4'b0010, 4'b0010, 4'b0010});
        tbl.push_back('{4'b0000, 4'b0000, 4'b0100});
        tbl.push_back('{4'b1000, 4'b1000, 4'b0100});
        tbl.push_back('{4'b0000, 4'b0000, 4'b0001});
        // Non-owner requests toggling during a grant have no effect.
        tbl.push_back('{4'b0101, 4'b0001, 4'b0001});
        tbl.push_back('{4'b0111, 4'b0001, 4'b0001});
        tbl.push_back('{4'b0101, 4'b0001, 4'b0001});
        tbl.push_back('{4'b0111, 4'b0001, 4'b0001});
        tbl.push_back('{4'b0100, 4'b0000, 4'b0010});
        tbl.push_back('{4'b0100, 4'b0100, 4'b0010});
        tbl.push_back('{4'b1100, 4'b0100, 4'b0010});
        tbl.push_back('{4'b1000, 4'b0000, 4'b1000});
        tbl.push_back('{4'b1000, 4'b1000, 4'b1000});

        rst = 1'b1;
        req = 4'b0000;
        #2;
        check_all("reset", 4'b0000, 4'b0001, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].req);
            check_all($sformatf("v%0d", i), tbl[i].gnt, tbl[i].ptr, 1'b0);
        end

        // Asynchronous reset in the middle of a grant to requester 3.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 4'b0000, 4'b0001, 1'b0);
        @(posedge clk);
        #1;
        check_all("rst_held", 4'b0000, 4'b0001, 1'b0);
        @(negedge clk);
        req = 4'b1010;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_rst_arb", 4'b0010, 4'b0001, 1'b0);
        step(4'b0000);
        check_all("post_rst_rel", 4'b0000, 4'b0100, 1'b0);

`ifdef RING_RR_ARBITER_TIMEOUT_EN
        // Owner 0 holds req: four grant cycles, then forced release.
        for (int c = 1; c <= 4; c++) begin
            step(4'b0001);
            check_all($sformatf("to_hold%0d", c), 4'b0001, 4'b0100, 1'b0);
        end
        step(4'b0001);
        check_all("to_release", 4'b0000, 4'b0010, 1'b1);
        step(4'b0001);
        check_all("to_masked1", 4'b0000, 4'b0010, 1'b0);
        step(4'b0001);
        check_all("to_masked2", 4'b0000, 4'b0010, 1'b0);
        step(4'b0000);
        check_all("to_drop", 4'b0000, 4'b0010, 1'b0);
        step(4'b0001);
        check_all("to_regrant", 4'b0001, 4'b0010, 1'b0);
        step(4'b0000);
        check_all("to_final_rel", 4'b0000, 4'b0010, 1'b0);
`else
        // Without the timeout feature a held grant never ends on its own.
        for (int c = 1; c <= 10; c++) begin
            step(4'b0001);
            check_all($sformatf("hold%0d", c), 4'b0001, 4'b0100, 1'b0);
        end
        step(4'b0000);
        check_all("hold_rel", 4'b0000, 4'b0010, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ring_rr_arbiter.md
RING_RR_ARBITER -- requirements
Module: ring_rr_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, maximum consecutive grant cycles before forced release (used only with RING_RR_ARBITER_TIMEOUT_EN); legal range 2..255.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  per-requester request level; bit i = requester i.
REQ-005 gnt  output 4  registered grant, one-hot or all-zero.
REQ-006 grant_id  output 2  binary index of the current owner; 0 when gnt=0.
REQ-007 busy  output 1  high while state=GRANT.
REQ-008 ptr  output 4  one-hot priority pointer; the highest-priority requester for the next arbitration.
REQ-009 timeout  output 1  one-cycle pulse on forced release; tied 0 without the macro.

Function
REQ-010 The block SHALL implement two states, IDLE and GRANT.
REQ-011 In IDLE, with any eligible req bit set, the block SHALL select the first eligible requester scanning from the ptr position upward with wrap (ptr bit, ptr+1, ... mod 4).
REQ-012 The selected gnt bit SHALL assert on the clock edge that samples the request (1-cycle latency), and the state SHALL become GRANT.
REQ-013 In IDLE with no eligible request, gnt SHALL be 0 and ptr SHALL be unchanged.
REQ-014 In GRANT, gnt SHALL hold while req[owner]=1, regardless of other requests.
REQ-015 When req[owner]=0 is sampled in GRANT, the next cycle SHALL have gnt=0, state=IDLE, and ptr=owner one-hot rotated left by one (bit3 wraps to bit0).
REQ-016 Exactly one gnt=0 turnaround cycle SHALL separate consecutive grants; back-to-back grants are forbidden.
REQ-017 Requests arriving or dropping for non-owners during GRANT SHALL have no effect on gnt or ptr.
REQ-018 ptr SHALL update only on release, never on grant.
REQ-019 grant_id SHALL equal the binary encoding of gnt in every cycle.
REQ-020 Starvation bound: a continuously requesting requester SHALL be granted within 3 other grants.

Reset
REQ-021 On rst=1, gnt SHALL be 4'b0000, grant_id=0, busy=0, timeout=0, ptr=4'b0001, state=IDLE, and the timeout counter and block mask SHALL be cleared, immediately and independently of clk.
REQ-022 Reset asserted during GRANT SHALL drop gnt asynchronously; after release, arbitration SHALL restart from ptr=0001.
REQ-023 The first arbitration after reset deassertion SHALL occur on the first rising edge with rst=0.

Configuration
REQ-024 Macro RING_RR_ARBITER_TIMEOUT_EN defined: a counter SHALL count GRANT cycles from 1; when the count equals TIMEOUT_CYCLES with req[owner] still 1, the next cycle SHALL have gnt=0, state=IDLE, timeout=1 for one cycle, and ptr advanced as in REQ-015.
REQ-025 With the macro defined, a force-released requester SHALL be masked (ineligible) until it deasserts req for at least one sampled cycle.
REQ-026 Macro undefined: no counter or mask SHALL exist, grants SHALL be unbounded, and timeout SHALL be constant 0.

Verification
REQ-027 Reset -> gnt=0000, ptr=0001, busy=0; req=1111 sampled -> gnt=0001 next cycle.
REQ-028 req=1111 held; each owner drops req for one cycle after 2 grant cycles -> grant order 0,1,2,3,0 with one gnt=0 cycle between grants and ptr sequence 0010,0100,1000,0001.
REQ-029 ptr=0100, req=0011 -> gnt=0001 (wrap scan); release -> ptr=0010.
REQ-030 rst pulsed mid-GRANT with gnt=1000 -> gnt=0000 asynchronously; ptr=0001 after release.
REQ-031 Macro defined, TIMEOUT_CYCLES=4, req=0001 held -> gnt=0001 for 4 cycles, then gnt=0, timeout=1 pulse, ptr=0010, no regrant until req[0] toggles low.
REQ-032 Non-owner req toggling during GRANT (req=0101 to 0111 to 0101, owner 0) -> gnt stays 0001 and ptr stays unchanged.
